// File: rtl/mem_lsu.sv
// Load/store unit between the core and a single-port word RAM.
// Sub-word stores are read-modify-write since the RAM lacks byte enables.
module mem_lsu #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-3:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW,
    S_ACK,
    S_ERR
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;

  logic                    w_accept;
  logic                    w_req_err;
  logic                    w_word_st;
  logic [DATA_WIDTH-1:0]   w_merge;
  logic [DATA_WIDTH-1:0]   w_load;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    logic m;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = |a;
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic        uns,
    input logic [1:0]  a
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    unique case (sz)
      SZ_B:    r = {{24{~uns & b[7]}}, b};
      SZ_H:    r = {{16{~uns & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane; the rest of the word is what the RAM held.
  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    logic [31:0] m;
    m = old;
    if (sz == SZ_H) begin
      m[{a[1], 4'b0000} +: 16] = wd[15:0];
    end else begin
      m[{a, 3'b000} +: 8] = wd[7:0];
    end
    return m;
  endfunction

  assign o_req_ready = (r_state == S_IDLE);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_req_err   = misaligned(i_req_size, i_req_addr[1:0]);
  assign w_word_st   = i_req_we & (i_req_size == SZ_W) & ~w_req_err;

  assign w_merge = merge(i_ram_data, r_wdata, r_size, r_addr[1:0]);
  assign w_load  = extract(i_ram_data, r_size, r_unsigned, r_addr[1:0]);

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

  always_comb begin
    o_ram_addr = r_addr[ADDR_WIDTH-1:2];
    o_ram_data = r_wdata;
    o_ram_we   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_ram_addr = i_req_addr[ADDR_WIDTH-1:2];
        o_ram_data = i_req_wdata;
        o_ram_we   = w_accept & w_word_st;
      end
      S_RMW: begin
        o_ram_data = w_merge;
        o_ram_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            if (w_req_err) begin
              r_state <= S_ERR;
            end else if (!i_req_we) begin
              r_state <= S_LOAD;
            end else if (w_word_st) begin
              r_state <= S_ACK;
            end else begin
              r_state <= S_RMW;
            end
          end
        end
        S_LOAD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_RMW: begin
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_ERR: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
